// File: rtl/snn_pkg.sv
// Shared types and helpers for the spiking-neuron blocks: default widths,
// neuron FSM states and the saturation-range helper used by every neuron.
package snn_pkg;

  localparam int V_WIDTH_DEF   = 8;
  localparam int I_WIDTH_DEF   = 5;
  localparam int REF_WIDTH_DEF = 3;
  localparam int CNT_WIDTH_DEF = 8;

  typedef enum logic [0:0] {
    ST_INTEGRATE = 1'b0,
    ST_REFRACT   = 1'b1
  } lif_state_e;

  // Reports whether x lies above ({1,0}) or below ({0,1}) the signed range of a w-bit word.
  function automatic logic [1:0] clamp_dir(input logic signed [31:0] x, input int w);
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    hi = (32'sd1 <<< (w - 1)) - 32'sd1;
    lo = -(32'sd1 <<< (w - 1));
    return {x > hi, x < lo};
  endfunction

endpackage

// File: rtl/lif_membrane_update.sv
// Combinational membrane update: arithmetic leak, add input current, clamp to the
// potential range and compare the clamped result against the firing threshold.
module lif_membrane_update
  import snn_pkg::*;
#(
  parameter int V_WIDTH = V_WIDTH_DEF,
  parameter int I_WIDTH = I_WIDTH_DEF
) (
  input  logic signed [V_WIDTH-1:0] v,
  input  logic signed [I_WIDTH-1:0] current,
  input  logic signed [V_WIDTH-1:0] threshold,
  input  logic        [2:0]         leak_shift,
  output logic signed [V_WIDTH-1:0] v_sat,
  output logic                      fire
);

  localparam int S_W = V_WIDTH + 2;

  logic signed [V_WIDTH-1:0] leak;
  logic signed [S_W-1:0]     v_ext;
  logic signed [S_W-1:0]     leak_ext;
  logic signed [S_W-1:0]     i_ext;
  logic signed [S_W-1:0]     sum;
  logic signed [31:0]        sum_wide;
  logic        [1:0]         dir;

  // Two guard bits keep V - leak + I exact before clamping.
  always_comb begin
    leak = '0;
    if (leak_shift != 3'd0) begin
      leak = v >>> leak_shift;
    end
    v_ext    = {{2{v[V_WIDTH-1]}}, v};
    leak_ext = {{2{leak[V_WIDTH-1]}}, leak};
    i_ext    = {{(S_W-I_WIDTH){current[I_WIDTH-1]}}, current};
    sum      = v_ext - leak_ext + i_ext;
    sum_wide = {{(32-S_W){sum[S_W-1]}}, sum};
    dir      = clamp_dir(sum_wide, V_WIDTH);
    if (dir[1]) begin
      v_sat = {1'b0, {(V_WIDTH-1){1'b1}}};
    end else if (dir[0]) begin
      v_sat = {1'b1, {(V_WIDTH-1){1'b0}}};
    end else begin
      v_sat = sum[V_WIDTH-1:0];
    end
    fire = (v_sat >= threshold);
  end

endmodule

// File: rtl/lif_spike_generator.sv
// Leaky integrate-and-fire neuron: one membrane update per step strobe, with
// threshold/fire/reset, refractory hold and a saturating spike counter.
module lif_spike_generator
  import snn_pkg::*;
#(
  parameter int V_WIDTH   = V_WIDTH_DEF,
  parameter int I_WIDTH   = I_WIDTH_DEF,
  parameter int REF_WIDTH = REF_WIDTH_DEF,
  parameter int CNT_WIDTH = CNT_WIDTH_DEF
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        clear,
  input  logic                        step,
  input  logic signed [I_WIDTH-1:0]   input_current,
  input  logic signed [V_WIDTH-1:0]   threshold,
  input  logic        [2:0]           leak_shift,
  input  logic        [REF_WIDTH-1:0] refractory_period,
  output logic                        out_valid,
  output logic                        spike_out,
  output logic signed [V_WIDTH-1:0]   membrane,
  output logic        [CNT_WIDTH-1:0] spike_count,
  output logic                        refractory
);

  lif_state_e               state;
  logic [REF_WIDTH-1:0]     ref_cnt;
  logic signed [V_WIDTH-1:0] v_sat;
  logic                     fire;

  lif_membrane_update #(
    .V_WIDTH (V_WIDTH),
    .I_WIDTH (I_WIDTH)
  ) u_update (
    .v          (membrane),
    .current    (input_current),
    .threshold  (threshold),
    .leak_shift (leak_shift),
    .v_sat      (v_sat),
    .fire       (fire)
  );

  assign refractory = (state == ST_REFRACT);

  // clear wins over step; a step taken while clearing produces no result.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_INTEGRATE;
      ref_cnt     <= '0;
      membrane    <= '0;
      spike_count <= '0;
      out_valid   <= 1'b0;
      spike_out   <= 1'b0;
    end else if (clear) begin
      state       <= ST_INTEGRATE;
      ref_cnt     <= '0;
      membrane    <= '0;
      spike_count <= '0;
      out_valid   <= 1'b0;
      spike_out   <= 1'b0;
    end else begin
      out_valid <= step;
      spike_out <= 1'b0;
      if (step) begin
        case (state)
          ST_INTEGRATE: begin
            if (fire) begin
              spike_out <= 1'b1;
              membrane  <= '0;
              if (spike_count != {CNT_WIDTH{1'b1}}) begin
                spike_count <= spike_count + CNT_WIDTH'(1);
              end
              if (refractory_period != '0) begin
                ref_cnt <= refractory_period;
                state   <= ST_REFRACT;
              end
            end else begin
              membrane <= v_sat;
            end
          end
          ST_REFRACT: begin
            membrane <= '0;
            ref_cnt  <= ref_cnt - REF_WIDTH'(1);
            if (ref_cnt == REF_WIDTH'(1)) begin
              state <= ST_INTEGRATE;
            end
          end
          default: state <= ST_INTEGRATE;
        endcase
      end
    end
  end

endmodule
